muldiv_seq: RTL and testbench
=============================

// Module: muldiv_seq
// PURPOSE
//   Multi-cycle sequencer for MULT/MULTU/DIV/DIVU beside the combinational ALU in EX.
//   Owns the HI/LO registers: iterative radix-2 multiply / restoring divide, one bit per cycle.
//   Holds busy while an operation runs; the hazard unit stalls EX on busy.
//   Serves MFHI/MFLO reads and MTHI/MTLO writes.
// PARAMETERS
//   WIDTH  32  operand width; HI/LO are WIDTH bits each; iteration count = WIDTH
// PORTS
//   clk       in   1        system clock, rising edge
//   reset     in   1        asynchronous, active-low reset
//   start     in   1        request a new operation; sampled only in IDLE
//   op        in   2        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a         in   WIDTH    multiplicand / dividend (rs)
//   b         in   WIDTH    multiplier / divisor (rt)
//   hi_we     in   1        MTHI write strobe
//   lo_we     in   1        MTLO write strobe
//   wdata     in   WIDTH    MTHI/MTLO data
//   busy      out  1        operation in flight (state != IDLE)
//   done      out  1        one-cycle pulse: HI/LO hold the new result
//   hi        out  WIDTH    HI register (mult: upper product; div: remainder)
//   lo        out  WIDTH    LO register (mult: lower product; div: quotient)
// BEHAVIOUR
//   Reset (any cycle, incl. mid-operation): state=IDLE, busy=0, done=0, hi=lo=0, counter=0.
//   FSM: IDLE -start-> PREP -> RUN (WIDTH cycles) -> FIX -> DONE -> IDLE.
//   start sampled in cycle T: PREP T+1, RUN T+2..T+33, FIX T+34, DONE T+35; latency 35.
//   PREP: latch op; signed ops take |a| and |b|; record sign_q=a[MSB]^b[MSB], sign_r=a[MSB].
//   RUN mult: 2*WIDTH-bit product register; add multiplicand on LSB=1, shift right.
//   RUN div: WIDTH+1-bit trial subtract; restore on negative; shift quotient bit in.
//   FIX: signed ops negate product if sign_q; negate quotient if sign_q; remainder if sign_r.
//   HI/LO are written on the FIX->DONE edge; done=1 only in DONE.
//   start in any state other than IDLE is ignored; no queueing.
//   hi_we/lo_we while busy=1 are ignored. In IDLE they write on the clock edge.
//   hi_we and lo_we together write both registers.
//   Unsigned ops treat the operands as raw bits; the sign-fix path is disabled.
//   Divide by zero (no trap): quotient all-ones, remainder |a|, then FIX applies.
//     DIVU 7/0 -> lo=FFFFFFFF, hi=7; DIV -7/0 -> lo=00000001, hi=FFFFFFF9.
//   DIV 80000000/FFFFFFFF -> lo=80000000, hi=0 (wraps, no flag).
//   Outputs hi/lo are direct register outputs; no combinational path from inputs.
// CONFIGURATION
//   MULDIV_DIV0_FLAG_EN defined: extra output port div_zero (1 bit).
//     div_zero pulses with done when op is DIVU/DIV and b==0 at start; reset value 0.
//   Undefined: no div_zero port or logic; divide-by-zero results unchanged.
// STRUCTURE
//   muldiv_pkg: op encodings (OP_MULTU..OP_DIV), FSM state enum, ITER_W = $clog2(WIDTH+1).
//   Sub-module muldiv_step: combinational WIDTH+1-bit add/sub for one iteration.
//   It is shared by the multiply-accumulate and trial-subtract paths.
//   muldiv_seq holds the FSM, counter, operand/result registers and the HI/LO file.
// TESTING
//   MULTU FFFFFFFF*FFFFFFFF -> done at T+35, hi=FFFFFFFE, lo=00000001.
//   MULT -3*5 (FFFFFFFD,00000005) -> hi=FFFFFFFF, lo=FFFFFFF1; busy high T+1..T+35.
//   DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF; DIVU 100/7 -> lo=0000000E, hi=00000002.
//   DIVU 7/0 -> lo=FFFFFFFF, hi=00000007.
//   With MULDIV_DIV0_FLAG_EN, div_zero=1 only in the done cycle.
//   Ignored requests during an op:
//     start at T+5 -> ignored, single done at T+35.
//     hi_we at T+10 with wdata=DEADBEEF -> ignored.
//     IDLE lo_we with 12345678 -> lo=12345678 next cycle.
//   Reset mid-op: drop reset low at T+20 -> busy=0, hi=lo=0 immediately.
//   After reset release, start -> normal 35-cycle result.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide sequencer: op codes, FSM states, counter sizing.
package muldiv_pkg;

    localparam int DEF_WIDTH = 32;

    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREP,
        ST_RUN,
        ST_FIX,
        ST_DONE
    } state_e;

    function automatic int iter_w(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int ITER_W = iter_w(DEF_WIDTH);

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: WIDTH+1-bit add (multiply) or trial subtract (divide).
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0] x,
    input  logic [WIDTH:0] y,
    input  logic           sub,
    output logic [WIDTH:0] res
);

    assign res = sub ? (x - y) : (x + y);

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; one bit per cycle, 35-cycle latency.
// Optional divide-by-zero flag output enabled by defining MULDIV_DIV0_FLAG_EN.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
`ifdef MULDIV_DIV0_FLAG_EN
    output logic             div_zero,
`endif
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = iter_w(WIDTH);

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 sgn_quot_q, sgn_quot_d;
    logic                 sgn_rem_q, sgn_rem_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 is_signed, is_div;
    logic [WIDTH-1:0]     upper, lower, a_abs, b_abs;
    logic [2*WIDTH-1:0]   prod_neg;
    logic [WIDTH:0]       step_x, step_y, step_res;

    // prod_q carries the raw {a,b} into PREP, then {remainder,quotient} or the product.
    assign upper     = prod_q[2*WIDTH-1:WIDTH];
    assign lower     = prod_q[WIDTH-1:0];
    assign is_signed = op_q[0];
    assign is_div    = op_q[1];
    assign a_abs     = (is_signed && upper[WIDTH-1]) ? -upper : upper;
    assign b_abs     = (is_signed && lower[WIDTH-1]) ? -lower : lower;
    assign prod_neg  = -prod_q;

    assign step_x = is_div ? {upper, lower[WIDTH-1]} : {1'b0, upper};
    assign step_y = {1'b0, opnd_q};

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .x   (step_x),
        .y   (step_y),
        .sub (is_div),
        .res (step_res)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        prod_d     = prod_q;
        opnd_d     = opnd_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        sgn_quot_d = sgn_quot_q;
        sgn_rem_d  = sgn_rem_q;
        cnt_d      = cnt_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (hi_we) hi_d = wdata;
                if (lo_we) lo_d = wdata;
                if (start) begin
                    state_d = ST_PREP;
                    op_d    = op;
                    prod_d  = {a, b};
                end
            end
            ST_PREP: begin
                sgn_quot_d = is_signed && (upper[WIDTH-1] ^ lower[WIDTH-1]);
                sgn_rem_d  = is_signed && upper[WIDTH-1];
                if (is_div) begin
                    prod_d = {{WIDTH{1'b0}}, a_abs};
                    opnd_d = b_abs;
                end else begin
                    prod_d = {{WIDTH{1'b0}}, b_abs};
                    opnd_d = a_abs;
                end
                cnt_d   = CNT_W'(WIDTH);
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Divide: a set MSB on the trial result means it went negative, so restore.
                if (is_div) begin
                    if (!step_res[WIDTH])
                        prod_d = {step_res[WIDTH-1:0], lower[WIDTH-2:0], 1'b1};
                    else
                        prod_d = {prod_q[2*WIDTH-2:0], 1'b0};
                end else if (prod_q[0]) begin
                    prod_d = {step_res, lower[WIDTH-1:1]};
                end else begin
                    prod_d = {1'b0, prod_q[2*WIDTH-1:1]};
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = ST_FIX;
            end
            ST_FIX: begin
                if (is_div) begin
                    lo_d = sgn_quot_q ? -lower : lower;
                    hi_d = sgn_rem_q  ? -upper : upper;
                end else begin
                    {hi_d, lo_d} = sgn_quot_q ? prod_neg : prod_q;
                end
                done_d  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            op_q       <= 2'b00;
            prod_q     <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            sgn_quot_q <= 1'b0;
            sgn_rem_q  <= 1'b0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            prod_q     <= prod_d;
            opnd_q     <= opnd_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            sgn_quot_q <= sgn_quot_d;
            sgn_rem_q  <= sgn_rem_d;
            cnt_q      <= cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

`ifdef MULDIV_DIV0_FLAG_EN
    logic dz_pend_q, dz_pend_d;
    logic div_zero_q, div_zero_d;

    always_comb begin
        dz_pend_d  = dz_pend_q;
        div_zero_d = 1'b0;
        if (state_q == ST_PREP) dz_pend_d = is_div && (lower == '0);
        if (state_q == ST_FIX)  div_zero_d = dz_pend_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dz_pend_q  <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            dz_pend_q  <= dz_pend_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign div_zero = div_zero_q;
`else
    // Divide by zero is silent in this build; results follow the all-ones quotient rule.
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed + scoreboard bench for muldiv_seq; also checks div_zero when MULDIV_DIV0_FLAG_EN is defined.
module tb_muldiv_seq;
    import muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy, done;
    logic [W-1:0] hi, lo;
`ifdef MULDIV_DIV0_FLAG_EN
    logic         div_zero;
    logic         expDz[$];
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [2*W-1:0] expQ[$];

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
`ifdef MULDIV_DIV0_FLAG_EN
        .div_zero (div_zero),
`endif
        .hi       (hi),
        .lo       (lo)
    );

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Independent reference using wide native arithmetic.
    function automatic logic [2*W-1:0] refModel(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [63:0] p;
        int sx, sy;
        sx = x;
        sy = y;
        case (o)
            OP_MULTU: return {32'h0, x} * {32'h0, y};
            OP_MULT: begin
                p = $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y});
                return p;
            end
            OP_DIVU: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                return {x % y, x / y};
            end
            default: begin
                if (y == 0) return {x, (x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
                return {32'(sx % sy), 32'(sx / sy)};
            end
        endcase
    endfunction

    // Called just after a negedge in IDLE; returns just after the next negedge (cycle T+1).
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [2*W-1:0] exp);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        expQ.push_back(exp);
`ifdef MULDIV_DIV0_FLAG_EN
        expDz.push_back(o[1] && (y == '0));
`endif
        @(negedge clk);
        start = 1'b0;
        compare("busy_t1", busy, 1'b1);
    endtask

    task automatic waitDone(input int startLat, output int lat);
        lat = startLat;
        while (done !== 1'b1 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic checkOutput(input string tag, input int lat);
        logic [2*W-1:0] exp;
        compare({tag, "_latency"}, lat, 35);
        compare({tag, "_busy_done"}, busy, 1'b1);
        compare({tag, "_sb_depth"}, expQ.size(), 1);
        exp = (expQ.size() > 0) ? expQ.pop_front() : 'x;
        compare({tag, "_hilo"}, {hi, lo}, exp);
`ifdef MULDIV_DIV0_FLAG_EN
        compare({tag, "_div_zero"}, div_zero, (expDz.size() > 0) ? expDz.pop_front() : 1'bx);
`endif
        @(negedge clk);
        compare({tag, "_idle_busy"}, busy, 1'b0);
        compare({tag, "_done_pulse"}, done, 1'b0);
`ifdef MULDIV_DIV0_FLAG_EN
        compare({tag, "_dz_pulse"}, div_zero, 1'b0);
`endif
    endtask

    task automatic runOp(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input logic [2*W-1:0] exp);
        int lat;
        applyStimulus(o, x, y, exp);
        waitDone(1, lat);
        checkOutput(tag, lat);
    endtask

    initial begin
        int lat;
        int extraDone;
        logic [1:0] ro;
        logic [W-1:0] ra, rb;

        repeat (2) @(negedge clk);
        compare("rst_busy", busy, 1'b0);
        compare("rst_done", done, 1'b0);
        compare("rst_hilo", {hi, lo}, 64'h0);
        reset = 1'b1;
        @(negedge clk);

        runOp("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        runOp("mult_m3x5", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 64'hFFFF_FFFF_FFFF_FFF1);
        runOp("div_m7d2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 64'hFFFF_FFFF_FFFF_FFFD);
        runOp("divu_100d7", OP_DIVU, 32'd100, 32'd7, 64'h0000_0002_0000_000E);
        runOp("divu_7d0", OP_DIVU, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
        runOp("div_m7d0", OP_DIV, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_0000_0001);
        runOp("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hCAFE_F00D;
        @(negedge clk);
        hi_we = 1'b0;
        lo_we = 1'b0;
        compare("mt_both", {hi, lo}, 64'hCAFE_F00D_CAFE_F00D);
        lo_we = 1'b1;
        wdata = 32'h1234_5678;
        @(negedge clk);
        lo_we = 1'b0;
        compare("mtlo_idle", {hi, lo}, 64'hCAFE_F00D_1234_5678);

        applyStimulus(OP_DIVU, 32'd1000, 32'd3, {32'd1, 32'd333});
        repeat (4) @(negedge clk);
        start = 1'b1;
        op = OP_MULTU;
        a = 32'd5;
        b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        hi_we = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        hi_we = 1'b0;
        compare("mthi_busy_ignored", hi, 32'hCAFE_F00D);
        waitDone(11, lat);
        checkOutput("ignored_start", lat);
        extraDone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) extraDone++;
        end
        compare("single_done", extraDone, 0);

        applyStimulus(OP_MULTU, 32'd3, 32'd7, 64'd21);
        repeat (19) @(negedge clk);
        reset = 1'b0;
        #1;
        compare("midrst_busy", busy, 1'b0);
        compare("midrst_hilo", {hi, lo}, 64'h0);
        expQ.delete();
`ifdef MULDIV_DIV0_FLAG_EN
        expDz.delete();
`endif
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        runOp("post_rst", OP_MULT, 32'h0001_0000, 32'hFFFF_0000, 64'hFFFF_FFFF_0000_0000);

        for (int i = 0; i < 6; i++) begin
            ro = 2'(i % 4);
            ra = $urandom;
            rb = (i == 5) ? 32'h0 : $urandom_range(32'hFFFF, 1);
            if (i == 4) rb = $urandom;
            runOp($sformatf("rand%0d", i), ro, ra, rb, refModel(ro, ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
